// File: rtl/sprite_line_renderer.sv
// Per-scanline sprite compositor: clears a fill line buffer, paints hit sprites from ROM
// in descending slot order with colour-key transparency, and serves pixels from the display buffer.
module sprite_line_renderer #(
    parameter int unsigned  NUM_SPRITES = 20,
    parameter int unsigned  SPRITE_SIZE = 32,
    parameter int unsigned  LINE_W      = 640,
    parameter logic [23:0]  BG_COLOR    = 24'h000000,
    parameter logic [23:0]  KEY_COLOR   = 24'hFF00FF,
    localparam int unsigned SZ_W        = $clog2(SPRITE_SIZE),
    localparam int unsigned ADDR_W      = 5 + 2 * SZ_W
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic [24*NUM_SPRITES-1:0] i_gl_array,
    input  logic                      i_line_req,
    input  logic [9:0]                i_line_y,
    output logic [ADDR_W-1:0]         o_rom_addr,
    input  logic [23:0]               i_rom_data,
    input  logic                      i_pix_valid,
    input  logic [9:0]                i_pix_x,
    output logic [23:0]               o_pix_rgb,
    output logic                      o_rgb_valid,
    output logic                      o_busy,
    output logic                      o_overrun
);

    localparam int unsigned       SLOT_W    = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SPRITES - 1);
    localparam logic [SZ_W-1:0]   LAST_COL  = SZ_W'(SPRITE_SIZE - 1);
    localparam logic [9:0]        LAST_CLR  = 10'(LINE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SCAN,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t              r_state;
    logic [23:0]         r_desc [NUM_SPRITES];
    logic [9:0]          r_line_y;
    logic                r_sel;
    logic                r_disp_ok;
    logic                r_busy;
    logic                r_overrun;
    logic [9:0]          r_clr_addr;
    logic [SLOT_W-1:0]   r_slot;
    logic [SZ_W-1:0]     r_row;
    logic [SZ_W-1:0]     r_col;
    logic                r_wr_valid;
    logic [SZ_W-1:0]     r_wr_col;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [23:0]         r_pix_rgb;
    logic                r_rgb_valid;
    logic [23:0]         r_mem [2][LINE_W];

    logic [23:0] w_desc;
    logic [4:0]  w_id;
    logic [9:0]  w_x;
    logic [8:0]  w_y;
    logic [9:0]  w_dy;
    logic        w_hit;
    logic [10:0] w_wsum;
    logic        w_we;
    logic [9:0]  w_waddr;
    logic [23:0] w_wdata;
    logic        w_fill_sel;

    assign w_desc     = r_desc[r_slot];
    assign w_id       = w_desc[23:19];
    assign w_x        = w_desc[18:9];
    assign w_y        = w_desc[8:0];
    assign w_dy       = r_line_y - {1'b0, w_y};
    assign w_hit      = (w_id != 5'd0) && (r_line_y >= {1'b0, w_y}) && (w_dy < 10'(SPRITE_SIZE));
    assign w_wsum     = {1'b0, w_x} + 11'(r_wr_col);
    assign w_fill_sel = ~r_sel;

    // Fill-buffer write port: background during CLEAR, otherwise the returning ROM word.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = BG_COLOR;
        if (!i_reset) begin
            if (r_state == S_CLEAR) begin
                w_we    = 1'b1;
                w_waddr = r_clr_addr;
            end else if (r_wr_valid && (i_rom_data != KEY_COLOR) && (w_wsum < 11'(LINE_W))) begin
                w_we    = 1'b1;
                w_waddr = w_wsum[9:0];
                w_wdata = i_rom_data;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_fill_sel][w_waddr] <= w_wdata;
        end
    end

    // Descriptor list and target line are frozen for the duration of a fill.
    always_ff @(posedge i_clk) begin
        if (i_line_req) begin
            for (int unsigned k = 0; k < NUM_SPRITES; k++) begin
                r_desc[k] <= i_gl_array[24*k +: 24];
            end
            r_line_y <= i_line_y;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_sel       <= 1'b0;
            r_disp_ok   <= 1'b0;
            r_busy      <= 1'b0;
            r_overrun   <= 1'b0;
            r_clr_addr  <= '0;
            r_slot      <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_wr_valid  <= 1'b0;
            r_wr_col    <= '0;
            r_rom_addr  <= '0;
            r_pix_rgb   <= '0;
            r_rgb_valid <= 1'b0;
        end else begin
            r_rgb_valid <= i_pix_valid;
            if (i_pix_valid) begin
                r_pix_rgb <= ((i_pix_x >= 10'(LINE_W)) || !r_disp_ok) ? BG_COLOR
                                                                      : r_mem[r_sel][i_pix_x];
            end

            r_wr_valid <= 1'b0;
            if (i_line_req) begin
                // A request during a fill abandons it and keeps showing the old line.
                if (r_state != S_IDLE) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_sel     <= ~r_sel;
                    r_disp_ok <= 1'b1;
                end
                r_state    <= S_CLEAR;
                r_clr_addr <= '0;
                r_busy     <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_CLEAR: begin
                        if (r_clr_addr == LAST_CLR) begin
                            r_state <= S_SCAN;
                            r_slot  <= LAST_SLOT;
                        end else begin
                            r_clr_addr <= r_clr_addr + 10'd1;
                        end
                    end
                    S_SCAN: begin
                        if (w_hit) begin
                            r_state    <= S_FETCH;
                            r_col      <= '0;
                            r_row      <= w_dy[SZ_W-1:0];
                            r_rom_addr <= {w_id, w_dy[SZ_W-1:0], SZ_W'(0)};
                        end else if (r_slot == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_slot <= r_slot - SLOT_W'(1);
                        end
                    end
                    S_FETCH: begin
                        r_wr_valid <= 1'b1;
                        r_wr_col   <= r_col;
                        if (r_col == LAST_COL) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_col      <= r_col + SZ_W'(1);
                            r_rom_addr <= {w_id, r_row, r_col + SZ_W'(1)};
                        end
                    end
                    S_DRAIN: begin
                        if (r_slot == '0) begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_SCAN;
                            r_slot  <= r_slot - SLOT_W'(1);
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rom_addr  = r_rom_addr;
    assign o_pix_rgb   = r_pix_rgb;
    assign o_rgb_valid = r_rgb_valid;
    assign o_busy      = r_busy;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_sprite_line_renderer.sv
// Bench for sprite_line_renderer: directed and random lines against a painter's-order line model.
module tb_sprite_line_renderer;

    localparam int NS = 20;
    localparam int SS = 32;
    localparam int LW = 640;
    localparam logic [23:0] BG  = 24'h000000;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [24*NS-1:0] gl_array = '0;
    logic             line_req = 1'b0;
    logic [9:0]       line_y = '0;
    logic [14:0]      rom_addr;
    logic [23:0]      rom_data = '0;
    logic             pix_valid = 1'b0;
    logic [9:0]       pix_x = '0;
    logic [23:0]      pix_rgb;
    logic             rgb_valid;
    logic             busy;
    logic             overrun;

    sprite_line_renderer dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_gl_array  (gl_array),
        .i_line_req  (line_req),
        .i_line_y    (line_y),
        .o_rom_addr  (rom_addr),
        .i_rom_data  (rom_data),
        .i_pix_valid (pix_valid),
        .i_pix_x     (pix_x),
        .o_pix_rgb   (pix_rgb),
        .o_rgb_valid (rgb_valid),
        .o_busy      (busy),
        .o_overrun   (overrun)
    );

    always #10 clk = ~clk;

    function automatic logic [23:0] rom_fn(input int id, input int row, input int col);
        int h;
        case (id)
            1: return 24'h00FF00;
            2: return ((col % 4) == 0) ? KEY : 24'hFF0000;
            3: return 24'h0000FF;
            default: begin
                if ((col % 7) == 3) return KEY;
                h = (id * 7919 + row * 131 + col * 17) * 40503;
                return 24'(h) ^ 24'h5A5A5A;
            end
        endcase
    endfunction

    // Synchronous sprite ROM: data one cycle after address.
    always @(posedge clk) begin
        rom_data <= rom_fn(int'(rom_addr[14:10]), int'(rom_addr[9:5]), int'(rom_addr[4:0]));
    end

    int          passed = 0;
    int          total  = 0;
    logic [23:0] desc      [NS];
    logic [23:0] exp_line  [LW];
    logic [23:0] disp_line [LW];
    int          exp_hits;
    logic [23:0] coinc_rgb;
    logic [23:0] coinc_old;
    logic [23:0] rd_rgb;
    logic        rd_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] mk(input int id, input int x, input int y);
        return {5'(id), 10'(x), 9'(y)};
    endfunction

    // Expected line: background, then every hit sprite painted from slot NS-1 down to slot 0.
    function automatic void model(input int ly);
        int id, sx, sy;
        exp_hits = 0;
        for (int p = 0; p < LW; p++) exp_line[p] = BG;
        for (int s = NS - 1; s >= 0; s--) begin
            id = int'(desc[s][23:19]);
            sx = int'(desc[s][18:9]);
            sy = int'(desc[s][8:0]);
            if (id != 0 && ly >= sy && (ly - sy) < SS) begin
                exp_hits++;
                for (int c = 0; c < SS; c++) begin
                    if (sx + c < LW && rom_fn(id, ly - sy, c) != KEY)
                        exp_line[sx + c] = rom_fn(id, ly - sy, c);
                end
            end
        end
    endfunction

    task automatic clear_desc();
        for (int k = 0; k < NS; k++) desc[k] = '0;
    endtask

    task automatic rand_desc(input int ly);
        int d, yy;
        for (int k = 0; k < NS; k++) begin
            d  = int'($urandom_range(0, 40));
            yy = (ly >= d) ? ly - d : int'($urandom_range(0, 511));
            desc[k] = mk(int'($urandom_range(0, 31)), int'($urandom_range(0, 700)), yy);
        end
    endtask

    task automatic start_line(input int ly, input bit swaps, input int cx);
        if (swaps) begin
            if (cx >= 0) coinc_old = disp_line[cx];
            disp_line = exp_line;
        end
        model(ly);
        for (int k = 0; k < NS; k++) gl_array[24*k +: 24] = desc[k];
        line_y   = 10'(ly);
        line_req = 1'b1;
        if (cx >= 0) begin
            pix_valid = 1'b1;
            pix_x     = 10'(cx);
        end
        tick();
        line_req  = 1'b0;
        pix_valid = 1'b0;
        coinc_rgb = pix_rgb;
        chk("busy_rise", 32'(busy), 32'd1);
    endtask

    task automatic wait_fill(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 4000) begin
            tick();
            n++;
        end
        chk({tag, "_fill_cycles"}, 32'(n), 32'(LW + NS + exp_hits * (SS + 1)));
    endtask

    task automatic read_pix(input int x);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        tick();
        pix_valid = 1'b0;
        rd_rgb    = pix_rgb;
        rd_v      = rgb_valid;
    endtask

    task automatic check_disp(input string tag);
        int bad = 0;
        for (int x = 0; x < LW; x++) begin
            pix_valid = 1'b1;
            pix_x     = 10'(x);
            tick();
            if (rgb_valid !== 1'b1 || pix_rgb !== disp_line[x]) bad++;
        end
        pix_valid = 1'b0;
        chk({tag, "_bad_pixels"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ly;
        clear_desc();
        for (int p = 0; p < LW; p++) exp_line[p] = BG;
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_rgb_valid", 32'(rgb_valid), 32'd0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        reset = 1'b0;

        read_pix(5);
        chk("no_line_valid", 32'(rd_v), 32'd1);
        chk("no_line_rgb", 32'(rd_rgb), 32'(BG));
        tick();
        chk("rgb_valid_drop", 32'(rgb_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_overrun", 32'(overrun), 32'd0);

        clear_desc();
        desc[3] = mk(1, 100, 50);
        start_line(52, 1'b1, -1);
        wait_fill("single");

        clear_desc();
        desc[0] = mk(2, 200, 10);
        desc[1] = mk(3, 200, 10);
        desc[5] = mk(1, 630, 5);
        start_line(12, 1'b1, -1);
        wait_fill("overlap");
        read_pix(99);  chk("single_x99", 32'(rd_rgb), 32'(BG));
        read_pix(100); chk("single_x100", 32'(rd_rgb), 32'h00FF00);
        read_pix(131); chk("single_x131", 32'(rd_rgb), 32'h00FF00);
        read_pix(132); chk("single_x132", 32'(rd_rgb), 32'(BG));
        check_disp("single_line");

        clear_desc();
        desc[3] = mk(1, 100, 50);
        start_line(49, 1'b1, 100);
        chk("coincident_pre_swap", 32'(coinc_rgb), 32'(coinc_old));
        chk("coincident_is_green", 32'(coinc_rgb), 32'h00FF00);
        wait_fill("y49_miss");
        read_pix(100); chk("post_swap_x100", 32'(rd_rgb), 32'(BG));
        read_pix(200); chk("key_shows_lower", 32'(rd_rgb), 32'h0000FF);
        read_pix(201); chk("slot0_on_top", 32'(rd_rgb), 32'hFF0000);
        read_pix(639); chk("clip_x639", 32'(rd_rgb), 32'h00FF00);
        read_pix(700); chk("x700_bg", 32'(rd_rgb), 32'(BG));
        check_disp("overlap_line");

        start_line(82, 1'b1, -1);
        wait_fill("y82_miss");
        check_disp("y49_line");

        start_line(81, 1'b1, -1);
        wait_fill("y81_row31");
        check_disp("y82_line");

        for (int r = 0; r < 4; r++) begin
            ly = int'($urandom_range(0, 470));
            rand_desc(ly);
            start_line(ly, 1'b1, -1);
            wait_fill("rand");
            check_disp("rand_prev_line");
        end

        for (int k = 0; k < NS; k++)
            desc[k] = mk(int'($urandom_range(1, 31)), int'($urandom_range(0, 639)),
                         300 - int'($urandom_range(0, 31)));
        start_line(300, 1'b1, -1);
        repeat (199) tick();
        chk("overrun_before", 32'(overrun), 32'd0);
        ly = int'($urandom_range(0, 470));
        rand_desc(ly);
        start_line(ly, 1'b0, -1);
        chk("overrun_set", 32'(overrun), 32'd1);
        wait_fill("after_overrun");
        chk("overrun_held", 32'(overrun), 32'd1);
        check_disp("disp_kept");

        rand_desc(100);
        start_line(100, 1'b1, -1);
        wait_fill("post_overrun");
        check_disp("refilled_line");
        chk("overrun_sticky", 32'(overrun), 32'd1);

        start_line(100, 1'b1, -1);
        repeat (660) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midfill_rst_busy", 32'(busy), 32'd0);
        chk("midfill_rst_overrun", 32'(overrun), 32'd0);
        chk("midfill_rst_rom_addr", 32'(rom_addr), 32'd0);
        read_pix(5);
        chk("midfill_rst_pix_bg", 32'(rd_rgb), 32'(BG));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
